// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter_if
//  Description : Bundle of the two write-requester channels (A = writeback,
//                B = load/debug) and the register-file write port driven by
//                regfile_wr_arbiter.
//
//                Requester channels (per requester X in {a, b}):
//                  x_valid  - requester has a write pending
//                  x_ready  - request accepted this cycle (combinational)
//                  x_addr   - destination register index
//                  x_data   - write data
//                Register-file side:
//                  wr_en / wr_addr / wr_data - registered write port
//                  busy                      - clear sequence in progress
//
//                Modports:
//                  slave  - the arbiter (consumes requests, drives write port)
//                  master - the requesters / register-file side
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
    parameter int NREGS = 32,
    parameter int WIDTH = 64
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic             a_valid;
    logic             a_ready;
    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_data;

    logic             b_valid;
    logic             b_ready;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_data;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output wr_en, wr_addr, wr_data, busy
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  wr_en, wr_addr, wr_data, busy
    );
endinterface : regfile_wr_arbiter_if
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Sequencer for the single write port of the register-file
//                array. After reset it clears every entry (one write per
//                cycle, addresses 0..NREGS-1, data 0), then shares the port
//                between requester A (writeback) and requester B
//                (load/debug) with round-robin arbitration on contested
//                cycles. Writes to ZERO_REG and to addresses >= NREGS are
//                acknowledged but never reach the array.
//
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous, active-high reset
//                bus          - regfile_wr_arbiter_if.slave (requester
//                               channels A/B, registered write port, busy)
//                conflict_cnt - [optional] saturating count of RUN cycles in
//                               which both requesters were valid
//
//  Build macro : REGFILE_WR_ARB_STATS_EN - when defined, adds the
//                conflict_cnt output and its counter. When undefined the
//                port does not exist and behaviour is otherwise identical.
//
//  Timing      : ready is combinational in the same cycle as valid; an
//                accepted request appears on wr_en/wr_addr/wr_data one
//                cycle later. One accepted write per cycle is sustainable.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int NREGS    = 32,
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  wire                     clk,
    input  wire                     reset,
    regfile_wr_arbiter_if.slave     bus
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    output logic [15:0]             conflict_cnt
`endif
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [AW-1:0] c_last_addr = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);
    localparam logic [AW-1:0] c_ptr_one   = AW'(1);

    // Round-robin memory: which requester won the most recent contested
    // cycle. Starting at B makes A the winner of the first contest.
    localparam logic c_rr_a = 1'b0;
    localparam logic c_rr_b = 1'b1;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [AW-1:0]    r_ptr;
    logic             r_rr_last;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [WIDTH-1:0] r_wr_data;

    // ------------------------------------------------------------------
    // Next-state / combinational outputs
    // ------------------------------------------------------------------
    state_t           w_state_next;
    logic [AW-1:0]    w_ptr_next;
    logic             w_rr_next;
    logic             w_wr_en_next;
    logic [AW-1:0]    w_wr_addr_next;
    logic [WIDTH-1:0] w_wr_data_next;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_contested;
    logic             w_a_in_range;
    logic             w_b_in_range;
    logic             w_a_keep;
    logic             w_b_keep;

    // ------------------------------------------------------------------
    // Address range qualification. When NREGS fills the address space
    // every encodable address is legal, so no comparator is built.
    // ------------------------------------------------------------------
    generate
        if (NREGS == (1 << AW)) begin : g_pow2_range
            assign w_a_in_range = 1'b1;
            assign w_b_in_range = 1'b1;
        end else begin : g_npow2_range
            assign w_a_in_range = (int'(bus.a_addr) < NREGS);
            assign w_b_in_range = (int'(bus.b_addr) < NREGS);
        end
    endgenerate

    // A granted request only turns into an array write if it targets a
    // real, writable entry; otherwise it is acknowledged and dropped.
    assign w_a_keep    = w_a_in_range && (bus.a_addr != c_zero_addr);
    assign w_b_keep    = w_b_in_range && (bus.b_addr != c_zero_addr);
    assign w_contested = bus.a_valid && bus.b_valid;

    // ------------------------------------------------------------------
    // State register and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_ptr     <= '0;
            r_rr_last <= c_rr_b;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_rr_last <= w_rr_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, arbitration and write-port selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_rr_next      = r_rr_last;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_grant_a      = 1'b0;
        w_grant_b      = 1'b0;

        case (r_state)
            S_CLEAR: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = r_ptr;
                w_wr_data_next = '0;
                w_ptr_next     = r_ptr + c_ptr_one;
                if (r_ptr == c_last_addr) begin
                    w_state_next = S_RUN;
                end
            end

            S_RUN: begin
                if (w_contested) begin
                    // Give the port to whoever did not win last time.
                    if (r_rr_last == c_rr_b) begin
                        w_grant_a = 1'b1;
                        w_rr_next = c_rr_a;
                    end else begin
                        w_grant_b = 1'b1;
                        w_rr_next = c_rr_b;
                    end
                end else if (bus.a_valid) begin
                    w_grant_a = 1'b1;
                end else if (bus.b_valid) begin
                    w_grant_b = 1'b1;
                end

                if (w_grant_a) begin
                    w_wr_en_next   = w_a_keep;
                    w_wr_addr_next = bus.a_addr;
                    w_wr_data_next = bus.a_data;
                end else if (w_grant_b) begin
                    w_wr_en_next   = w_b_keep;
                    w_wr_addr_next = bus.b_addr;
                    w_wr_data_next = bus.b_data;
                end
            end

            default: begin
                w_state_next = S_CLEAR;
                w_ptr_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Readies are masked while reset is asserted so that no
    // request is acknowledged in a cycle whose write is being cancelled.
    // ------------------------------------------------------------------
    assign bus.a_ready = w_grant_a && !reset;
    assign bus.b_ready = w_grant_b && !reset;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = (r_state == S_CLEAR);

`ifdef REGFILE_WR_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Contention statistics: saturating count of RUN cycles with both
    // requesters valid. Clear-phase cycles are not counted.
    // ------------------------------------------------------------------
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if ((r_state == S_RUN) && w_contested &&
                     (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule : regfile_wr_arbiter
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wr_arbiter
//  Description : Self-checking bench for regfile_wr_arbiter. Expected writes
//                are queued when requests are driven and compared one cycle
//                later when the registered write port updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int NREGS    = 32;
    localparam int WIDTH    = 64;
    localparam int AW       = 5;
    localparam int ZERO_REG = 31;

    typedef struct {
        logic             en;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREGS(NREGS), .WIDTH(WIDTH)) bus ();

`ifdef REGFILE_WR_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    regfile_wr_arbiter #(
        .NREGS    (NREGS),
        .WIDTH    (WIDTH),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef REGFILE_WR_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic             m_rr;      // 1 = B won last contest
    logic [AW-1:0]    m_addr;
    logic [WIDTH-1:0] m_data;
    logic             exp_ar;
    logic             exp_br;
    wr_t              exp_q[$];

    // Drive one cycle of requests at the falling edge and queue the write
    // that must appear after the following rising edge.
    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [WIDTH-1:0] bd);
        wr_t  e;
        logic ga;
        logic gb;
        @(negedge clk);
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
        ga = av && (!bv || m_rr);
        gb = bv && !ga;
        if (av && bv) m_rr = gb;
        exp_ar = ga;
        exp_br = gb;
        if (ga) begin
            m_addr = aa; m_data = ad;
        end else if (gb) begin
            m_addr = ba; m_data = bd;
        end
        e.en   = (ga || gb) && (m_addr != AW'(ZERO_REG));
        e.addr = m_addr;
        e.data = m_data;
        exp_q.push_back(e);
    endtask

    task automatic model_after_clear();
        m_rr   = 1'b1;
        m_addr = AW'(NREGS - 1);
        m_data = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        bus.a_addr = '0; bus.b_addr = '0; bus.a_data = '0; bus.b_data = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.a_ready, bus.b_ready} !==
            {1'b0, {AW{1'b0}}, {WIDTH{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: en=%b addr=%0d data=%h busy=%b ar=%b br=%b, expected 0 0 0 1 0 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.a_ready, bus.b_ready);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        reset = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 5'd3;
        bus.b_valid = 1'b1; bus.b_addr = 5'd4;
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_start: ar=%b br=%b busy=%b, expected 0 0 1", bus.a_ready, bus.b_ready, bus.busy);
        end
        for (int k = 0; k < NREGS; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(k) || bus.wr_data !== '0 ||
                bus.busy !== (k != NREGS - 1)) begin
                errors++;
                $display("FAIL clear_step%0d: en=%b addr=%0d data=%h busy=%b, expected 1 %0d 0 %b",
                         k, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, k, (k != NREGS - 1));
            end
            if (k != NREGS - 1) begin
                checks++;
                if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_ready%0d: ar=%b br=%b, expected 0 0", k, bus.a_ready, bus.b_ready);
                end
            end
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        model_after_clear();
    endtask

    task automatic test_single_a();
        wr_t e;
        drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'h0);
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_a_ready: ar=%b br=%b, expected 1 0", bus.a_ready, bus.b_ready);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 64'hDEAD_BEEF ||
            {e.en, e.addr, e.data} !== {1'b1, 5'd5, 64'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_a_write: en=%b addr=%0d data=%h, expected 1 5 deadbeef",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_contested();
        wr_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 64'hA0 + 64'(i), 1'b1, 5'd2, 64'hB0 + 64'(i));
            #1;
            checks++;
            if (bus.a_ready !== (i % 2 == 0) || bus.b_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL contested_grant%0d: ar=%b br=%b, expected %b %b",
                         i, bus.a_ready, bus.b_ready, (i % 2 == 0), (i % 2 == 1));
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== ((i % 2 == 0) ? 5'd1 : 5'd2) ||
                bus.wr_data !== e.data) begin
                errors++;
                $display("FAIL contested_write%0d: en=%b addr=%0d data=%h, expected 1 %0d %h",
                         i, bus.wr_en, bus.wr_addr, bus.wr_data, (i % 2 == 0) ? 1 : 2, e.data);
            end
        end
    endtask

    task automatic test_zero_reg();
        wr_t e;
        drive(1'b1, 5'd31, 64'h1, 1'b0, 5'd0, 64'h0);
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_reg_ready: ar=%b, expected 1", bus.a_ready);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.wr_en !== 1'b0 || e.en !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_write: en=%b, expected 0", bus.wr_en);
        end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1, 2: drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h100 + 64'(i));
                3:       drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
                4:       drive(1'b1, 5'd0, 64'hAA, 1'b0, 5'd0, 64'h0);
                default: drive(1'b1, 5'd9, 64'h55, 1'b1, 5'd31, 64'h77);
            endcase
            #1;
            checks++;
            if (bus.a_ready !== exp_ar || bus.b_ready !== exp_br || (bus.a_ready && bus.b_ready)) begin
                errors++;
                $display("FAIL b2b_ready%0d: ar=%b br=%b, expected %b %b", i, bus.a_ready, bus.b_ready, exp_ar, exp_br);
            end
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b2b_queue%0d: queue empty, expected one entry", i);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.wr_en !== e.en || bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL b2b_write%0d: en=%b addr=%0d data=%h, expected %b %0d %h",
                             i, bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        reset = 1'b1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (bus.wr_addr !== 5'd10 || bus.wr_en !== 1'b1) begin
            errors++;
            $display("FAIL midclear_pos: en=%b addr=%0d, expected 1 10", bus.wr_en, bus.wr_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midclear_reset: en=%b busy=%b, expected 0 1", bus.wr_en, bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midclear_restart: en=%b addr=%0d busy=%b, expected 1 0 1",
                     bus.wr_en, bus.wr_addr, bus.busy);
        end
        repeat (NREGS - 1) @(posedge clk);
        #1;
        checks++;
        if (bus.wr_addr !== 5'd31 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_end: addr=%0d busy=%b, expected 31 0", bus.wr_addr, bus.busy);
        end
        model_after_clear();
    endtask

`ifdef REGFILE_WR_ARB_STATS_EN
    task automatic test_stats();
        wr_t e;
        @(negedge clk);
        reset = 1'b1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: cnt=%0d, expected 0", conflict_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        repeat (NREGS) @(posedge clk);
        #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        checks++;
        if (conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: cnt=%0d, expected 0", conflict_cnt);
        end
        model_after_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd3, 64'h30 + 64'(i), (i < 3), 5'd4, 64'h40 + 64'(i));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.wr_en !== e.en || bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                errors++;
                $display("FAIL stats_write%0d: en=%b addr=%0d data=%h, expected %b %0d %h",
                         i, bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.addr, e.data);
            end
        end
        checks++;
        if (conflict_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stats_count: cnt=%0d, expected 3", conflict_cnt);
        end
        @(negedge clk);
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_saturate: cnt=%h, expected ffff", conflict_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_clear();
        test_single_a();
        test_contested();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid_clear();
`ifdef REGFILE_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter
`default_nettype wire
